// File: rtl/la_mailbox.sv
// LA-driven command mailbox: firmware posts opcode/operand with a request
// toggle on the LA probes; the block executes it and answers with an ack toggle.
// Optional build macro: LA_MAILBOX_SYNC_EN adds a 2-flop synchronizer on the
// masked LA inputs ahead of request detection and operand capture.
module la_mailbox #(
    parameter logic [15:0] STATUS_RST = 16'h0000,
    parameter logic [31:0] RUN_MAX    = 32'hFFFF_FFFF
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic [127:0] la_data_in,
    input  logic [127:0] la_oenb,
    output logic [127:0] la_data_out,
    output logic [37:0]  io_out,
    output logic [37:0]  io_oeb
);

    localparam int unsigned IN_W    = 37;
    localparam int unsigned REQ_BIT = 36;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_SETS  = 4'd1;
    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_RUN   = 4'd3;
    localparam logic [3:0] OP_READ  = 4'd4;
    localparam logic [3:0] OP_CHECK = 4'd5;
    localparam logic [3:0] OP_CLR   = 4'd6;

    typedef enum logic [1:0] {S_IDLE, S_DEC, S_EXEC, S_RESP} state_t;

    logic [IN_W-1:0] la_in_m;
    logic [IN_W-1:0] src;
    logic            req_rst_c;
    logic            req_c;
    logic            unused_la;

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic [3:0]  opcode_q, opcode_d;
    logic [31:0] operand_q, operand_d;
    logic [31:0] run_cnt_q, run_cnt_d;
    logic [31:0] counter_q, counter_d;
    logic [31:0] result_q, result_d;
    logic [15:0] status_q, status_d;
    logic        ack_q, ack_d;
    logic        busy_q, busy_d;
    logic        overrun_q, overrun_d;
    logic        illegal_q, illegal_d;

    // Only SoC-driven LA bits are visible; undriven bits read as 0
    assign la_in_m   = la_data_in[IN_W-1:0] & ~la_oenb[IN_W-1:0];
    assign unused_la = ^{la_data_in[127:IN_W], la_oenb[127:IN_W]};

`ifdef LA_MAILBOX_SYNC_EN
    logic [IN_W-1:0] sync1_q;
    logic [IN_W-1:0] sync2_q;

    // Two-flop synchronizer on the masked LA inputs
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= la_in_m;
            sync2_q <= sync1_q;
        end
    end

    assign src       = sync2_q;
    assign req_rst_c = 1'b0;
`else
    assign src       = la_in_m;
    assign req_rst_c = la_in_m[REQ_BIT];
`endif

    assign req_c = src[REQ_BIT] ^ req_q;

    // Next-state and command execution
    always_comb begin
        state_d   = state_q;
        req_d     = src[REQ_BIT];
        opcode_d  = opcode_q;
        operand_d = operand_q;
        run_cnt_d = run_cnt_q;
        counter_d = counter_q;
        result_d  = result_q;
        status_d  = status_q;
        ack_d     = ack_q;
        busy_d    = busy_q;
        overrun_d = overrun_q;
        illegal_d = illegal_q;

        case (state_q)
            S_IDLE: begin
                if (req_c) begin
                    opcode_d  = src[35:32];
                    operand_d = src[31:0];
                    busy_d    = 1'b1;
                    state_d   = S_DEC;
                end
            end
            S_DEC: begin
                run_cnt_d = (operand_q > RUN_MAX) ? RUN_MAX : operand_q;
                state_d   = S_EXEC;
            end
            S_EXEC: begin
                case (opcode_q)
                    OP_LOAD: counter_d = operand_q;
                    OP_CLR:  counter_d = '0;
                    OP_RUN: begin
                        if (run_cnt_q != 32'd0) begin
                            counter_d = counter_q + 32'd1;
                            run_cnt_d = run_cnt_q - 32'd1;
                        end
                    end
                    default: ;
                endcase
                if (!((opcode_q == OP_RUN) && (run_cnt_q != 32'd0))) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                case (opcode_q)
                    OP_NOP, OP_LOAD: ;
                    OP_SETS: status_d = operand_q[15:0];
                    OP_RUN, OP_READ: result_d = counter_q;
                    OP_CHECK: begin
                        if (counter_q == operand_q) begin
                            result_d = 32'd1;
                            status_d = status_q + 16'd1;
                        end else begin
                            result_d = 32'd0;
                            status_d = 16'hDEAD;
                        end
                    end
                    OP_CLR: begin
                        overrun_d = 1'b0;
                        illegal_d = 1'b0;
                    end
                    default: illegal_d = 1'b1;
                endcase
                ack_d   = ~ack_q;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Requests arriving outside IDLE (including the RESP cycle) are dropped
        if (req_c && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            req_q     <= req_rst_c;
            opcode_q  <= '0;
            operand_q <= '0;
            run_cnt_q <= '0;
            counter_q <= '0;
            result_q  <= '0;
            status_q  <= STATUS_RST;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            run_cnt_q <= run_cnt_d;
            counter_q <= counter_d;
            result_q  <= result_d;
            status_q  <= status_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
            illegal_q <= illegal_d;
        end
    end

    assign la_data_out = {32'd0, counter_q, 28'd0, illegal_q, overrun_q, busy_q, ack_q, result_q};
    assign io_out      = {6'd0, status_q, 16'd0};
    assign io_oeb      = {6'h3F, 16'h0000, 16'hFFFF};

endmodule

// File: tb/tb_la_mailbox.sv
// Directed bench for la_mailbox: vector table plus multi-cycle corner sequences.
module tb_la_mailbox;

`ifdef LA_MAILBOX_SYNC_EN
    localparam int SYNC_X = 2;
`else
    localparam int SYNC_X = 0;
`endif

    logic         clk;
    logic         rst;
    logic [127:0] la_data_in;
    logic [127:0] la_oenb;
    logic [127:0] la_data_out;
    logic [37:0]  io_out;
    logic [37:0]  io_oeb;

    logic         req_lvl;
    int           n_checks;
    int           n_err;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] opnd;
        int          lat;
        logic [31:0] res;
        logic [15:0] st;
        logic        ill;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[14];

    la_mailbox dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .la_data_in  (la_data_in),
        .la_oenb     (la_oenb),
        .la_data_out (la_data_out),
        .io_out      (io_out),
        .io_oeb      (io_oeb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] opnd);
        req_lvl = ~req_lvl;
        la_data_in[31:0]  = opnd;
        la_data_in[35:32] = op;
        la_data_in[36]    = req_lvl;
    endtask

    // Edge offset (0 = first sampling edge) at which ack toggles, -1 on timeout
    task automatic wait_ack(input int budget, output int lat);
        logic a0;
        a0  = la_data_out[32];
        lat = -1;
        for (int n = 0; n < budget; n++) begin
            step();
            if (la_data_out[32] !== a0) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int   lat;
        logic a_snap;

        n_checks   = 0;
        n_err      = 0;
        req_lvl    = 1'b0;
        rst        = 1'b1;
        la_data_in = '0;
        la_oenb    = '0;

        //                op     operand        lat res            status    ill   counter
        vecs[0]  = '{4'd1, 32'h0000_AB60,  3, 32'd0,         16'hAB60, 1'b0, 32'd0};
        vecs[1]  = '{4'd2, 32'd0,          3, 32'd0,         16'hAB60, 1'b0, 32'd0};
        vecs[2]  = '{4'd3, 32'd10,        13, 32'd10,        16'hAB60, 1'b0, 32'd10};
        vecs[3]  = '{4'd5, 32'd10,         3, 32'd1,         16'hAB61, 1'b0, 32'd10};
        vecs[4]  = '{4'd5, 32'd11,         3, 32'd0,         16'hDEAD, 1'b0, 32'd10};
        vecs[5]  = '{4'd4, 32'd0,          3, 32'd10,        16'hDEAD, 1'b0, 32'd10};
        vecs[6]  = '{4'd0, 32'h1234_5678,  3, 32'd10,        16'hDEAD, 1'b0, 32'd10};
        vecs[7]  = '{4'd2, 32'hFFFF_FFFE,  3, 32'd10,        16'hDEAD, 1'b0, 32'hFFFF_FFFE};
        vecs[8]  = '{4'd3, 32'd3,          6, 32'd1,         16'hDEAD, 1'b0, 32'd1};
        vecs[9]  = '{4'd3, 32'd0,          3, 32'd1,         16'hDEAD, 1'b0, 32'd1};
        vecs[10] = '{4'd9, 32'h0000_5555,  3, 32'd1,         16'hDEAD, 1'b1, 32'd1};
        vecs[11] = '{4'd6, 32'd0,          3, 32'd1,         16'hDEAD, 1'b0, 32'd0};
        vecs[12] = '{4'd1, 32'h0000_1234,  3, 32'd1,         16'h1234, 1'b0, 32'd0};
        vecs[13] = '{4'd5, 32'd0,          3, 32'd1,         16'h1235, 1'b0, 32'd0};

        // Reset for two cycles with LA inputs low
        step();
        step();
        chk("rst_status", 128'(io_out[31:16]), 128'(16'h0000));
        chk("rst_io_out", 128'(io_out), 128'(38'd0));
        chk("rst_io_oeb", 128'(io_oeb), 128'({6'h3F, 16'h0000, 16'hFFFF}));
        chk("rst_la_out", la_data_out, 128'd0);
        rst = 1'b0;
        step();
        step();
        chk("post_rst_la_out", la_data_out, 128'd0);

        // Back-to-back table commands; each next send lands on the earliest accept edge
        for (int i = 0; i < 14; i++) begin
            send(vecs[i].op, vecs[i].opnd);
            wait_ack(200, lat);
            chk($sformatf("v%0d_latency", i), 128'(lat), 128'(vecs[i].lat + SYNC_X));
            chk($sformatf("v%0d_result", i), 128'(la_data_out[31:0]), 128'(vecs[i].res));
            chk($sformatf("v%0d_status", i), 128'(io_out[31:16]), 128'(vecs[i].st));
            chk($sformatf("v%0d_busy", i), 128'(la_data_out[33]), 128'(1'b0));
            chk($sformatf("v%0d_overrun", i), 128'(la_data_out[34]), 128'(1'b0));
            chk($sformatf("v%0d_illegal", i), 128'(la_data_out[35]), 128'(vecs[i].ill));
            chk($sformatf("v%0d_counter", i), 128'(la_data_out[95:64]), 128'(vecs[i].cnt));
        end

        // Overrun: second toggle during a long RUN is dropped
        send(4'd3, 32'd100);
        step();
        step();
        step();
        chk("ovr_busy", 128'(la_data_out[33]), 128'(1'b1));
        step();
        step();
        send(4'd0, 32'd0);
        wait_ack(250, lat);
        chk("ovr_latency", 128'(lat), 128'(98));
        chk("ovr_flag", 128'(la_data_out[34]), 128'(1'b1));
        chk("ovr_result", 128'(la_data_out[31:0]), 128'(32'd100));
        chk("ovr_counter", 128'(la_data_out[95:64]), 128'(32'd100));
        a_snap = la_data_out[32];
        for (int i = 0; i < 20; i++) step();
        chk("ovr_single_ack", 128'(la_data_out[32]), 128'(a_snap));
        chk("ovr_idle", 128'(la_data_out[33]), 128'(1'b0));
        send(4'd6, 32'd0);
        wait_ack(200, lat);
        chk("clr_latency", 128'(lat), 128'(3 + SYNC_X));
        chk("clr_overrun", 128'(la_data_out[34]), 128'(1'b0));
        chk("clr_counter", 128'(la_data_out[95:64]), 128'(32'd0));

        // Masked request bit is ignored
        if (req_lvl) begin
            send(4'd0, 32'd0);
            wait_ack(200, lat);
            chk("mask_prep_latency", 128'(lat), 128'(3 + SYNC_X));
        end
        la_oenb[36] = 1'b1;
        step();
        la_data_in[35:32] = 4'd1;
        la_data_in[31:0]  = 32'h0000_BEEF;
        la_data_in[36]    = 1'b1;
        a_snap = la_data_out[32];
        for (int i = 0; i < 10; i++) step();
        chk("mask_busy", 128'(la_data_out[33]), 128'(1'b0));
        chk("mask_ack", 128'(la_data_out[32]), 128'(a_snap));
        chk("mask_status", 128'(io_out[31:16]), 128'(16'h1235));
        la_data_in[36] = 1'b0;
        step();
        la_oenb[36] = 1'b0;
        step();
        step();

        // Illegal opcode with the mask cleared
        send(4'd9, 32'd0);
        wait_ack(200, lat);
        chk("ill_latency", 128'(lat), 128'(3 + SYNC_X));
        chk("ill_flag", 128'(la_data_out[35]), 128'(1'b1));
        chk("ill_status", 128'(io_out[31:16]), 128'(16'h1235));

        // Reset aborts a RUN in progress
        send(4'd3, 32'd50);
        for (int i = 0; i < 10; i++) step();
        chk("abort_busy", 128'(la_data_out[33]), 128'(1'b1));
        chk("abort_live_counter", 128'(la_data_out[95:64]), 128'(8 - SYNC_X));
        rst        = 1'b1;
        la_data_in = '0;
        req_lvl    = 1'b0;
        step();
        chk("abort_la_out", la_data_out, 128'd0);
        chk("abort_io_out", 128'(io_out), 128'(38'd0));
        chk("abort_io_oeb", 128'(io_oeb), 128'({6'h3F, 16'h0000, 16'hFFFF}));
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("abort_quiet", la_data_out, 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
